// File: rtl/wptr_full_handler.sv
// Write-side pointer and flag controller for an asynchronous FIFO.
// Keeps the binary write pointer, publishes its Gray form, and derives full/level flags from the synchronised read pointer.
module wptr_full_handler #(
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              w_en,
  input  logic [ADDR_W:0]   g_rptr,
  input  logic              ovf_clr,
  output logic [ADDR_W-1:0] waddr,
  output logic              w_accept,
  output logic [ADDR_W:0]   wptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              overflow
);

  localparam logic [ADDR_W:0] AF_T = (ADDR_W+1)'(AF_THRESH);

  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic            full_q, full_d;
  logic            almost_full_q, almost_full_d;
  logic [ADDR_W:0] wlevel_q, wlevel_d;
  logic            overflow_q, overflow_d;

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] full_pattern;
  logic [ADDR_W:0] level_calc;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  assign rbin[ADDR_W] = g_rptr[ADDR_W];
  generate
    for (genvar gi = ADDR_W - 1; gi >= 0; gi--) begin : g_rbin
      assign rbin[gi] = rbin[gi+1] ^ g_rptr[gi];
    end
  endgenerate

  // In Gray space, "one full lap ahead" means the top two bits are inverted.
  assign full_pattern = {~g_rptr[ADDR_W:ADDR_W-1], g_rptr[ADDR_W-2:0]};

  assign w_accept = w_en & ~full_q;

  always_comb begin
    wbin_d        = wbin_q + {{ADDR_W{1'b0}}, w_accept};
    wptr_d        = (wbin_d >> 1) ^ wbin_d;
    level_calc    = wbin_d - rbin;
    full_d        = (wptr_d == full_pattern);
    wlevel_d      = level_calc;
    almost_full_d = (level_calc >= AF_T);
    overflow_d    = overflow_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    // A fresh overflow event outranks a simultaneous clear.
    if (w_en && full_q) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q        <= '0;
      wptr_q        <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      wlevel_q      <= '0;
      overflow_q    <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wptr_q        <= wptr_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      wlevel_q      <= wlevel_d;
      overflow_q    <= overflow_d;
    end
  end

  assign waddr       = wbin_q[ADDR_W-1:0];
  assign wptr        = wptr_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wlevel      = wlevel_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_wptr_full_handler.sv
// Scoreboard bench for wptr_full_handler: stimulus pushes expected outputs, a negedge monitor pops and compares.
// The reference model tracks plain integer write/read counts and derives every flag from their difference.
module tb_wptr_full_handler;

  localparam int ADDR_W    = 4;
  localparam int AF_THRESH = 12;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int PSPAN     = 1 << (ADDR_W + 1);

  logic              wclk = 1'b0;
  logic              wrst;
  logic              w_en;
  logic [ADDR_W:0]   g_rptr;
  logic              ovf_clr;
  logic [ADDR_W-1:0] waddr;
  logic              w_accept;
  logic [ADDR_W:0]   wptr;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   wlevel;
  logic              overflow;

  wptr_full_handler #(.ADDR_W(ADDR_W), .AF_THRESH(AF_THRESH)) dut (
    .wclk(wclk), .wrst(wrst), .w_en(w_en), .g_rptr(g_rptr), .ovf_clr(ovf_clr),
    .waddr(waddr), .w_accept(w_accept), .wptr(wptr), .full(full),
    .almost_full(almost_full), .wlevel(wlevel), .overflow(overflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    bit in_rst;
    int acc;
    int waddr;
    int wptr;
    int full;
    int af;
    int level;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int txn    = 0;
  bit stim_done = 0;

  // Reference model: total accepted writes and total reads seen by the write side.
  int wr = 0;
  int rd = 0;
  int m_full = 0, m_af = 0, m_level = 0, m_ovf = 0;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%0d expected=%0d", name, txn, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit wen, input bit clr, input int rd_new);
    exp_t e;
    int   lvl;
    rd      = rd_new;
    wrst    = rst;
    w_en    = wen;
    ovf_clr = clr;
    g_rptr  = (ADDR_W+1)'(gray(rd % PSPAN));
    e.in_rst = rst;
    e.acc    = (wen && m_full == 0) ? 1 : 0;
    e.waddr  = wr % DEPTH;
    e.wptr   = gray(wr % PSPAN);
    e.full   = m_full;
    e.af     = m_af;
    e.level  = m_level;
    e.ovf    = m_ovf;
    exp_q.push_back(e);
    if (rst) begin
      wr = 0; rd = 0;
      m_full = 0; m_af = 0; m_level = 0; m_ovf = 0;
    end else begin
      if (wen && m_full != 0) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (e.acc != 0) wr++;
      lvl     = wr - rd;
      m_level = lvl;
      m_full  = (lvl == DEPTH) ? 1 : 0;
      m_af    = (lvl >= AF_THRESH) ? 1 : 0;
    end
    @(posedge wclk);
    #1;
  endtask

  // Monitor: every cycle is an output cycle for this block.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        if (!e.in_rst) chk("w_accept", int'(w_accept), e.acc);
        chk("waddr", int'(waddr), e.waddr);
        chk("wptr", int'(wptr), e.wptr);
        chk("full", int'(full), e.full);
        chk("almost_full", int'(almost_full), e.af);
        chk("wlevel", int'(wlevel), e.level);
        chk("overflow", int'(overflow), e.ovf);
        $display("txn %0d rst=%0b w_en=%0b clr=%0b waddr=%0d wptr=%0h full=%0b af=%0b lvl=%0d ovf=%0b acc=%0b",
                 txn, wrst, w_en, ovf_clr, waddr, wptr, full, almost_full, wlevel, overflow, w_accept);
      end
    end
  end

  initial begin
    int r;
    wrst = 1'b1; w_en = 1'b1; ovf_clr = 1'b0; g_rptr = '0;
    @(posedge wclk);
    #1;
    // Reset held with writes requested: nothing moves.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    // Fill with read pointer parked at zero, then one overflow attempt.
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0);
    // Overflow clear, then set-over-clear priority.
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    // Drain release by one and refill.
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    // Wrap with the reader trailing closely.
    for (int i = 0; i < 40; i++) step(0, 1, 0, wr - 1);
    step(0, 0, 0, wr - 1);
    // Mid-fill reset.
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    // Randomized traffic with lagging reader and occasional reset.
    for (int i = 0; i < 400; i++) begin
      r = rd;
      if ($urandom_range(0, 3) == 0) r = rd + int'($urandom_range(0, wr - rd));
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), r);
    end
    step(0, 0, 0, rd);
    stim_done = 1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 5000) begin
      @(posedge wclk);
      budget++;
    end
    if (!stim_done) begin
      checks++; errors++;
      $display("FAIL timeout stimulus did not complete in %0d cycles", budget);
    end
    repeat (3) @(posedge wclk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
